// File: rtl/freq_meas_pkg.sv
// Shared encodings, gate table and default thresholds for the auto-ranging
// frequency measurement sequencer.
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_EVAL,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        LK_NONE,
        LK_UP,
        LK_DOWN
    } lock_t;

    // Gate lengths 10 ms, 100 ms, 1 s, 2 s as (gate_time+1) x 10 ms
    localparam logic [3:0][7:0] GATE_TBL = {8'd199, 8'd99, 8'd9, 8'd0};
    localparam logic [1:0]  IDX_START       = 2'd1;
    localparam logic [15:0] LOW_THRESH_DEF  = 16'd100;
    localparam logic [15:0] HIGH_THRESH_DEF = 16'd60000;

    function automatic logic [7:0] gate_of(input logic [1:0] idx);
        return GATE_TBL[idx];
    endfunction

endpackage

// File: rtl/freq_meas_sequencer_if.sv
// Host/counter-facing signal bundle of the sequencer; slave is the sequencer side.
interface freq_meas_sequencer_if;
    logic        start;
    logic        stop;
    logic        cont;
    logic        meas_oe;
    logic [7:0]  gate_time;
    logic        data_en;
    logic [23:0] frequency;
    logic [23:0] result;
    logic        result_valid;
    logic [1:0]  range_idx;
    logic        err;
    logic        busy;

    modport master (
        output start, stop, cont, data_en, frequency,
        input  meas_oe, gate_time, result, result_valid, range_idx, err, busy
    );

    modport slave (
        input  start, stop, cont, data_en, frequency,
        output meas_oe, gate_time, result, result_valid, range_idx, err, busy
    );
endinterface

// File: rtl/freq_meas_sequencer_ms_tick_gen.sv
// 10 ms tick prescaler: counts while clr is low, emits a one-cycle tick and a
// saturating count of ticks since the last clear.
module ms_tick_gen #(
    parameter int MS_DIV = 500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    output logic        tick,
    output logic [15:0] tick_cnt
);
    localparam int DW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [DW-1:0] div;
    logic          wrap;

    assign wrap = (div == DW'(MS_DIV - 1));
    assign tick = !clr && wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            tick_cnt <= '0;
        end else if (clr) begin
            div      <= '0;
            tick_cnt <= '0;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap && tick_cnt != '1)
                tick_cnt <= tick_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/freq_meas_sequencer.sv
// Auto-ranging controller for the reciprocal pulse counter: arms, measures,
// re-ranges with a one-direction lock and reports one validated result per run.
module freq_meas_sequencer
    import freq_meas_pkg::*;
#(
    parameter int          MS_DIV      = 500_000,
    parameter int          ARM_CYCLES  = 4,
    parameter int          TO_MARGIN   = 20,
    parameter logic [15:0] LOW_THRESH  = LOW_THRESH_DEF,
    parameter logic [15:0] HIGH_THRESH = HIGH_THRESH_DEF
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    freq_meas_sequencer_if.slave bus
);
    localparam int AW = $clog2(ARM_CYCLES + 1);

    state_t        state, state_nxt;
    lock_t         lock;
    logic [1:0]    idx, range_r;
    logic [23:0]   cap, result_r;
    logic          err_r;
    logic [AW-1:0] arm_cnt;
    logic          tick;
    logic [15:0]   tick_cnt, limit;
    logic [15:0]   hz;
    logic          cap_en, timeout, go_up, go_down, report;

    ms_tick_gen #(.MS_DIV(MS_DIV)) u_tick (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .clr      (state != ST_MEAS),
        .tick     (tick),
        .tick_cnt (tick_cnt)
    );

    assign hz    = cap[23:8];
    assign limit = {8'd0, bus.gate_time} + 16'(1 + TO_MARGIN);

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        timeout   = 1'b0;
        go_up     = 1'b0;
        go_down   = 1'b0;
        report    = 1'b0;
        if (bus.stop) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.start) state_nxt = ST_ARM;
                ST_ARM:  if (arm_cnt == AW'(ARM_CYCLES - 1)) state_nxt = ST_MEAS;
                ST_MEAS: begin
                    // A capture on the timeout tick still counts as a reading
                    if (bus.data_en) begin
                        cap_en    = 1'b1;
                        state_nxt = ST_EVAL;
                    end else if (tick && tick_cnt >= limit) begin
                        timeout   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                ST_EVAL: begin
                    if (hz < LOW_THRESH && idx != 2'd3 && lock != LK_DOWN) begin
                        go_up     = 1'b1;
                        state_nxt = ST_ARM;
                    end else if (hz >= HIGH_THRESH && idx != 2'd0 && lock != LK_UP) begin
                        go_down   = 1'b1;
                        state_nxt = ST_ARM;
                    end else begin
                        report    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: state_nxt = bus.cont ? ST_ARM : ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            lock     <= LK_NONE;
            idx      <= IDX_START;
            cap      <= '0;
            arm_cnt  <= '0;
            result_r <= '0;
            range_r  <= IDX_START;
            err_r    <= 1'b0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= (state == ST_ARM && state_nxt == ST_ARM) ? arm_cnt + 1'b1 : '0;
            if (cap_en) cap <= bus.frequency;
            if (go_up) begin
                idx  <= idx + 2'd1;
                lock <= LK_UP;
            end else if (go_down) begin
                idx  <= idx - 2'd1;
                lock <= LK_DOWN;
            end else if (state_nxt == ST_ARM && (state == ST_IDLE || state == ST_DONE)) begin
                lock <= LK_NONE;
            end
            if (report) begin
                result_r <= cap;
                range_r  <= idx;
                err_r    <= 1'b0;
            end else if (timeout) begin
                // A dead input in continuous mode retries on the next shorter gate
                result_r <= '0;
                range_r  <= idx;
                err_r    <= 1'b1;
                if (bus.cont && idx != 2'd0) idx <= idx - 2'd1;
            end
        end
    end

    assign bus.meas_oe      = (state == ST_MEAS);
    assign bus.gate_time    = gate_of(idx);
    assign bus.result       = result_r;
    assign bus.result_valid = (state == ST_DONE);
    assign bus.range_idx    = range_r;
    assign bus.err          = err_r;
    assign bus.busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: behavioural counter model, vector table with a
// result scoreboard, and hand sequences for continuous mode, stop and reset.
module tb_freq_meas_sequencer;
    import freq_meas_pkg::*;

    localparam int MS_DIV     = 50;
    localparam int ARM_CYCLES = 4;
    // OE stays low through EVAL and DONE as well as ARM between continuous passes
    localparam int OE_GAP     = ARM_CYCLES + 2;
    // one 100 ms pass: OE-low gap, 10 ticks of gate, one cycle counter latency
    localparam int PERIOD_1   = OE_GAP + 10 * MS_DIV + 1;

    typedef struct {
        logic [23:0] res;
        logic [1:0]  ri;
        logic        e;
    } exp_t;

    typedef struct {
        logic [3:0][23:0] f;
        logic             nosig;
        logic [23:0]      res;
        logic [1:0]       ri;
        logic             e;
        int               passes;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    freq_meas_sequencer_if bus();

    freq_meas_sequencer #(.MS_DIV(MS_DIV), .ARM_CYCLES(ARM_CYCLES)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int valids = 0;
    int oe_rises = 0;
    logic oe_d = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    logic [3:0][23:0] freq_tbl;
    logic             no_sig;
    int               oe_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] gidx(input logic [7:0] g);
        case (g)
            8'd0:    return 2'd0;
            8'd9:    return 2'd1;
            8'd99:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Counter model: data_en rises (gate_time+1) ticks after OE rises, held until OE drops
    always_comb bus.frequency = freq_tbl[gidx(bus.gate_time)];

    always @(posedge clk) begin
        if (bus.meas_oe !== 1'b1) begin
            oe_cyc      <= 0;
            bus.data_en <= 1'b0;
        end else begin
            oe_cyc <= oe_cyc + 1;
            if (!no_sig && oe_cyc + 1 >= (int'(bus.gate_time) + 1) * MS_DIV)
                bus.data_en <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.meas_oe === 1'b1 && oe_d !== 1'b1) oe_rises++;
        oe_d = bus.meas_oe;
        if (bus.result_valid === 1'b1) begin
            valids++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: result %0h range %0d err %0d", bus.result, bus.range_idx, bus.err);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(bus.result), 32'(mon_e.res));
                chk("range_idx", 32'(bus.range_idx), 32'(mon_e.ri));
                chk("err", 32'(bus.err), 32'(mon_e.e));
            end
        end
    end

    function automatic vec_t mk(input logic [23:0] f0, f1, f2, f3, input logic ns,
                                input logic [23:0] res, input logic [1:0] ri, input logic e, input int p);
        vec_t v;
        v.f = {f3, f2, f1, f0};
        v.nosig = ns; v.res = res; v.ri = ri; v.e = e; v.passes = p;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_meas_oe"}, 32'(bus.meas_oe), 0);
        chk({tag, "_gate_time"}, 32'(bus.gate_time), 9);
        chk({tag, "_result"}, 32'(bus.result), 0);
        chk({tag, "_valid"}, 32'(bus.result_valid), 0);
        chk({tag, "_range_idx"}, 32'(bus.range_idx), 1);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        exp_t e;
        do_reset();
        freq_tbl = v.f;
        no_sig   = v.nosig;
        bus.cont = 1'b0;
        e.res = v.res; e.ri = v.ri; e.e = v.e;
        sb.push_back(e);
        valids   = 0;
        oe_rises = 0;
        pulse_start();
        for (int c = 0; c < 40000 && bus.busy === 1'b1; c++) @(negedge clk);
        chk($sformatf("v%0d_idle", n), 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_valids", n), 32'(valids), 1);
        chk($sformatf("v%0d_passes", n), 32'(oe_rises), 32'(v.passes));
        chk($sformatf("v%0d_sb_empty", n), 32'(sb.size()), 0);
    endtask

    vec_t vt[9];
    int   vstamp[4];
    int   gaps[3];

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cont  = 1'b0;
        freq_tbl  = '0;
        no_sig    = 1'b0;

        vt[0] = mk(24'h03E800, 24'h03E800, 24'h03E800, 24'h03E800, 0, 24'h03E800, 2'd1, 0, 1);
        vt[1] = mk(24'h001400, 24'h001400, 24'h001400, 24'h001400, 0, 24'h001400, 2'd3, 0, 3);
        vt[2] = mk(24'hF23000, 24'hF23000, 24'hF23000, 24'hF23000, 0, 24'hF23000, 2'd0, 0, 2);
        vt[3] = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 1, 24'h000000, 2'd1, 1, 1);
        vt[4] = mk(24'hF23000, 24'h003200, 24'hEE4800, 24'h001400, 0, 24'hEE4800, 2'd2, 0, 2);
        vt[5] = mk(24'h003200, 24'hF23000, 24'h003200, 24'h003200, 0, 24'h003200, 2'd0, 0, 2);
        vt[6] = mk(24'h006400, 24'h006400, 24'h006400, 24'h006400, 0, 24'h006400, 2'd1, 0, 1);
        vt[7] = mk(24'hEA6000, 24'hEA6000, 24'hEA6000, 24'hEA6000, 0, 24'hEA6000, 2'd0, 0, 2);
        vt[8] = mk(24'hEA5FFF, 24'hEA5FFF, 24'hEA5FFF, 24'hEA5FFF, 0, 24'hEA5FFF, 2'd1, 0, 1);

        do_reset();
        check_reset_vals("rst0");

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Continuous mode: fixed period and fixed OE-low gap between passes
        do_reset();
        freq_tbl = {4{24'h03E800}};
        no_sig   = 1'b0;
        bus.cont = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{res: 24'h03E800, ri: 2'd1, e: 1'b0});
        begin
            int nv = 0, ng = 0, low = 0, cyc = 0;
            logic seen_fall = 1'b0, prev_oe = 1'b0;
            pulse_start();
            while (nv < 4 && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                if (bus.meas_oe) begin
                    if (seen_fall && !prev_oe && ng < 3) begin
                        gaps[ng] = low;
                        ng++;
                    end
                    low = 0;
                end else begin
                    low++;
                    if (prev_oe) seen_fall = 1'b1;
                end
                prev_oe = bus.meas_oe;
                if (bus.result_valid) begin
                    vstamp[nv] = cyc;
                    nv++;
                end
            end
            bus.stop = 1'b1;
            bus.cont = 1'b0;
            @(negedge clk);
            bus.stop = 1'b0;
            chk("cont_results", 32'(nv), 4);
            for (int i = 1; i < 4; i++)
                chk($sformatf("cont_period%0d", i), 32'(vstamp[i] - vstamp[i-1]), 32'(PERIOD_1));
            for (int i = 0; i < 2; i++)
                chk($sformatf("cont_oe_gap%0d", i), 32'(gaps[i]), 32'(OE_GAP));
            chk("cont_stopped", 32'(bus.busy), 0);
        end

        // Stop mid-MEAS: next cycle idle, no result, outputs held
        pulse_start();
        for (int c = 0; c < 100 && bus.meas_oe !== 1'b1; c++) @(negedge clk);
        repeat (50) @(negedge clk);
        valids   = 0;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_busy", 32'(bus.busy), 0);
        chk("stop_meas_oe", 32'(bus.meas_oe), 0);
        chk("stop_result_held", 32'(bus.result), 32'h03E800);
        chk("stop_range_held", 32'(bus.range_idx), 1);
        repeat (700) @(negedge clk);
        chk("stop_no_valid", 32'(valids), 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);
        chk("start_stop_busy", 32'(bus.busy), 0);

        // Timeout in continuous mode steps the next gate down
        do_reset();
        no_sig   = 1'b1;
        bus.cont = 1'b1;
        sb.push_back('{res: 24'h0, ri: 2'd1, e: 1'b1});
        pulse_start();
        for (int c = 0; c < 3000 && bus.result_valid !== 1'b1; c++) @(negedge clk);
        chk("to_valid_seen", 32'(bus.result_valid), 1);
        chk("to_gate_down", 32'(bus.gate_time), 0);
        bus.cont = 1'b0;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("to_stopped", 32'(bus.busy), 0);

        // Async reset mid-ARM
        no_sig = 1'b0;
        pulse_start();
        chk("arm_busy", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1 chk("rst_edge_meas_oe", 32'(bus.meas_oe), 0);
        chk("rst_edge_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst1");
        chk("sb_final_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
